// File: rtl/cache_sim_pkg.sv
// Shared types for the cache simulator front end.
// Holds the trace request record and the fixed-width helper typedefs.
package cache_sim_pkg;
    typedef logic [15:0] u16;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam int DEFAULT_ADDRESS_SIZE = 16;

    typedef struct packed {
        logic                            rw;
        logic [DEFAULT_ADDRESS_SIZE-1:0] address;
    } trace_req_t;
endpackage

// File: rtl/trace_fifo.sv
// Circular request buffer: head visible combinationally, push/pop take effect at the edge.
// No internal backpressure; the owner must not push when full or pop when empty.
module trace_fifo
    import cache_sim_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter type elem_t = trace_req_t,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  elem_t         push_data,
    input  logic          pop,
    output elem_t         pop_data,
    output logic [CW-1:0] count
);
    elem_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/trace_issue_queue.sv
// Buffers trace requests and issues one per unstalled cycle into the cache; push-to-issue latency 2 edges.
// in_ready drops when full, in reset or flushing; stall freezes the issue register while pushes continue.
module trace_issue_queue
    import cache_sim_pkg::*;
#(
    parameter int  ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
    parameter int  DEPTH        = 8,
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_rw,
    input  logic [ADDRESS_SIZE-1:0] in_address,
    input  logic                    flush,
    input  logic                    stall,
    output logic                    rw,
    output logic [ADDRESS_SIZE-1:0] address,
    output logic                    req_valid,
    output logic [CW-1:0]           count,
    output logic [31:0]             issued_reads,
    output logic [31:0]             issued_writes
);
    // Same layout as trace_req_t, sized to this instance's address width.
    typedef struct packed {
        logic                    rw;
        logic [ADDRESS_SIZE-1:0] address;
    } req_t;

    req_t in_req;
    req_t head;
    logic push;
    logic pop;

    assign in_req   = '{rw: in_rw, address: in_address};
    assign in_ready = (count < CW'(DEPTH)) && !reset && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = !reset && !flush && !stall && (count != '0);

    trace_fifo #(
        .DEPTH  (DEPTH),
        .elem_t (req_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (in_req),
        .pop       (pop),
        .pop_data  (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rw            <= 1'b0;
            address       <= '0;
            req_valid     <= 1'b0;
            issued_reads  <= '0;
            issued_writes <= '0;
        end else if (flush) begin
            req_valid <= 1'b0;
        end else if (!stall) begin
            req_valid <= pop;
            if (pop) begin
                rw      <= head.rw;
                address <= head.address;
                // Counters stick at all-ones rather than wrapping.
                if (head.rw) begin
                    if (issued_writes != '1) issued_writes <= issued_writes + 32'd1;
                end else begin
                    if (issued_reads != '1) issued_reads <= issued_reads + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_trace_issue_queue.sv
// Bench for trace_issue_queue: reference queue model checked every edge plus directed sequences.
module tb_trace_issue_queue;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic        rw;
        logic [15:0] a;
    } req_t;

    typedef struct {
        logic        reset;
        logic        in_valid;
        logic        in_rw;
        logic [15:0] in_address;
        logic        flush;
        logic        stall;
        logic        exp_vld;
        logic        exp_rw;
        logic [15:0] exp_addr;
        logic [3:0]  exp_count;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_rw = 1'b0;
    logic [15:0] in_address = '0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        in_ready;
    logic        rw;
    logic [15:0] address;
    logic        req_valid;
    logic [3:0]  count;
    logic [31:0] issued_reads;
    logic [31:0] issued_writes;

    int   checks = 0;
    int   errors = 0;
    req_t mq[$];
    int   er = 0;
    int   ew = 0;
    int   total_pushed = 0;
    bit   last_pushed = 1'b0;

    trace_issue_queue #(.ADDRESS_SIZE(16), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rw         (in_rw),
        .in_address    (in_address),
        .flush         (flush),
        .stall         (stall),
        .rw            (rw),
        .address       (address),
        .req_valid     (req_valid),
        .count         (count),
        .issued_reads  (issued_reads),
        .issued_writes (issued_writes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on every edge from the inputs seen at that edge.
    always @(posedge clk) begin
        logic r, f, s, v, irw;
        logic [15:0] ia;
        int sz;
        req_t e;
        r = reset; f = flush; s = stall; v = in_valid; irw = in_rw; ia = in_address;
        sz = mq.size();
        #1;
        last_pushed = 1'b0;
        if (r) begin
            mq.delete();
            er = 0;
            ew = 0;
            chk("reset_req_valid", 64'(req_valid), 64'd0);
            chk("reset_rw", 64'(rw), 64'd0);
            chk("reset_address", 64'(address), 64'd0);
        end else if (f) begin
            mq.delete();
            chk("flush_req_valid", 64'(req_valid), 64'd0);
        end else begin
            if (!s && sz > 0) begin
                e = mq.pop_front();
                chk("issue_req_valid", 64'(req_valid), 64'd1);
                chk("issue_rw", 64'(rw), 64'(e.rw));
                chk("issue_address", 64'(address), 64'(e.a));
                if (e.rw) ew++;
                else      er++;
            end else if (!s) begin
                chk("idle_req_valid", 64'(req_valid), 64'd0);
            end
            if (v && sz < DEPTH) begin
                mq.push_back('{rw: irw, a: ia});
                last_pushed = 1'b1;
                total_pushed++;
            end
        end
        chk("count", 64'(count), 64'(mq.size()));
        chk("issued_reads", 64'(issued_reads), 64'(er));
        chk("issued_writes", 64'(issued_writes), 64'(ew));
        chk("in_ready", 64'(in_ready), 64'(!reset && !flush && mq.size() < DEPTH));
    end

    // Valid/ready source: holds each request until accepted, optionally toggling stall.
    task automatic stream(input int n, input bit toggle_stall);
        int sent = 0;
        int cyc = 0;
        while (sent < n && cyc < 1000) begin
            @(negedge clk);
            if (in_valid && last_pushed) sent++;
            if (sent < n) begin
                if (!in_valid || last_pushed) begin
                    in_rw      = 1'($urandom_range(1, 0));
                    in_address = 16'($urandom_range(16'hffff, 0));
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (toggle_stall) stall = cyc[0];
            cyc++;
        end
        chk("stream_timeout", 64'(sent), 64'(n));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    vec_t vecs[6];
    int   base_sum;
    int   base_pushed;
    logic [31:0] save_r, save_w;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 4'd1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hABCD, 4'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD, 4'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b1, 16'hABCD, 4'd1};

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].reset; in_valid = vecs[i].in_valid; in_rw = vecs[i].in_rw;
            in_address = vecs[i].in_address; flush = vecs[i].flush; stall = vecs[i].stall;
            @(posedge clk);
            #2;
            chk("vec_req_valid", 64'(req_valid), 64'(vecs[i].exp_vld));
            chk("vec_rw", 64'(rw), 64'(vecs[i].exp_rw));
            chk("vec_address", 64'(address), 64'(vecs[i].exp_addr));
            chk("vec_count", 64'(count), 64'(vecs[i].exp_count));
        end
        @(negedge clk);
        in_valid = 1'b0;
        stall = 1'b0;
        idle(2);
        chk("t1_reads", 64'(issued_reads), 64'd2);
        chk("t1_writes", 64'(issued_writes), 64'd1);

        // Fill under stall, offer a ninth, then drain in order.
        stall = 1'b1;
        stream(8, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_rw = 1'b1; in_address = 16'hBEEF;
        @(posedge clk);
        #2;
        chk("full_count", 64'(count), 64'd8);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        stall = 1'b0;
        idle(10);
        chk("drained_count", 64'(count), 64'd0);

        // Simultaneous push/pop at count 3, then a long stream across pointer wrap.
        stall = 1'b1;
        stream(3, 1'b0);
        @(negedge clk);
        stall = 1'b0; in_valid = 1'b1; in_rw = 1'b0; in_address = 16'h0303;
        @(posedge clk);
        #2;
        chk("pushpop_count", 64'(count), 64'd3);
        @(negedge clk);
        in_valid = 1'b0;
        stream(20, 1'b0);
        idle(6);

        // Flush with five queued and a push on offer.
        stall = 1'b1;
        stream(5, 1'b0);
        save_r = issued_reads;
        save_w = issued_writes;
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_rw = 1'b1; in_address = 16'hDEAD;
        @(posedge clk);
        #2;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_vld", 64'(req_valid), 64'd0);
        chk("flush_reads_kept", 64'(issued_reads), 64'(save_r));
        chk("flush_writes_kept", 64'(issued_writes), 64'(save_w));
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
        idle(5);

        // Reset mid-stream with counters at 10/7 and four queued.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_rw = (i >= 10); in_address = 16'(16'h100 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        idle(3);
        chk("pre_reset_reads", 64'(issued_reads), 64'd10);
        chk("pre_reset_writes", 64'(issued_writes), 64'd7);
        stall = 1'b1;
        stream(4, 1'b0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; in_address = 16'h7777;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_reads", 64'(issued_reads), 64'd0);
        chk("rst_writes", 64'(issued_writes), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; in_valid = 1'b1; in_rw = 1'b0; in_address = 16'h0042;
        @(negedge clk);
        in_valid = 1'b0;
        idle(2);
        chk("post_reset_reads", 64'(issued_reads), 64'd1);
        chk("post_reset_address", 64'(address), 64'h0042);

        // Stall toggling every cycle under a continuous stream.
        base_sum = int'(issued_reads + issued_writes);
        base_pushed = total_pushed;
        stream(30, 1'b1);
        stall = 1'b0;
        idle(12);
        chk("toggle_drained", 64'(count), 64'd0);
        chk("toggle_issued", 64'(int'(issued_reads + issued_writes) - base_sum),
            64'(total_pushed - base_pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
